// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback over a shared
// single-port memory, with retired-instruction counter and sticky error/halt.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       mode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             wb_sel,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [2:0] MODE_BR = 3'b000;
  localparam logic [2:0] MODE_R  = 3'b001;
  localparam logic [2:0] MODE_I  = 3'b010;
  localparam logic [2:0] MODE_SW = 3'b011;
  localparam logic [2:0] MODE_LW = 3'b100;

  state_t     cur_state, nxt_state;
  logic [2:0] mode_q;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       err_set;
  logic       waiting;

  // Timeout fires on the MEM_TIMEOUT-th consecutive not-ready cycle of an access.
  assign timeout = (wait_cnt == 8'(MEM_TIMEOUT - 1));
  assign waiting = (cur_state == FETCH || cur_state == MEM) && !mem_ready;

  always_comb begin
    nxt_state    = cur_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = 1'b0;
    wb_sel       = 1'b0;
    err_set      = 1'b0;
    unique case (cur_state)
      IDLE: if (start) nxt_state = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          nxt_state = DECODE;
        end else if (timeout) begin
          err_set   = 1'b1;
          nxt_state = HALT;
        end
      end
      DECODE: begin
        if (mode > MODE_LW) begin
          err_set   = 1'b1;
          nxt_state = HALT;
        end else begin
          nxt_state = EXEC;
        end
      end
      EXEC: begin
        case (mode_q)
          MODE_BR: begin
            pc_we     = 1'b1;
            pc_sel    = 1'b1;
            nxt_state = stop ? IDLE : FETCH;
          end
          MODE_R, MODE_I:   nxt_state = WB;
          MODE_SW, MODE_LW: nxt_state = MEM;
          default:          nxt_state = HALT;
        endcase
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (mode_q == MODE_SW);
        if (mem_ready) begin
          if (mode_q == MODE_SW) begin
            pc_we     = 1'b1;
            nxt_state = stop ? IDLE : FETCH;
          end else begin
            nxt_state = WB;
          end
        end else if (timeout) begin
          err_set   = 1'b1;
          nxt_state = HALT;
        end
      end
      WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        reg_dst   = (mode_q == MODE_R);
        wb_sel    = (mode_q == MODE_LW);
        nxt_state = stop ? IDLE : FETCH;
      end
      HALT:    nxt_state = HALT;
      default: nxt_state = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= IDLE;
      err       <= 1'b0;
      retired   <= '0;
      mode_q    <= '0;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      if (err_set) err <= 1'b1;
      if (pc_we) retired <= retired + 1'b1;
      if (cur_state == DECODE) mode_q <= mode;
      // Count only while staying in the same access; any exit restarts at zero.
      if (waiting && nxt_state == cur_state) wait_cnt <= wait_cnt + 8'd1;
      else wait_cnt <= '0;
    end
  end

  assign busy  = (cur_state != IDLE) && (cur_state != HALT);
  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: per-instruction transaction model
// (cycle cost, strobe counts, strobe values) plus directed halt/reset scenarios.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop;
  logic [2:0]  mode;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel;
  logic        reg_we, reg_dst, wb_sel, busy, err;
  logic [31:0] retired;
  logic [2:0]  state;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  longint unsigned exp_retired = 0;

  multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .busy(busy),
    .err(err), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH; df/dm = not-ready cycles before each access completes.
  task automatic run_instr(input logic [2:0] m, input int unsigned df,
                           input int unsigned dm, input logic stp);
    int unsigned cyc = 0, n_req = 0, n_addr = 0, n_we = 0, n_ir = 0;
    int unsigned n_pc = 0, n_reg = 0, n_bad = 0, waited = 0;
    int unsigned base, exp_cyc;
    logic psel = 1'b0, rdst = 1'b0, wsel = 1'b0, done = 1'b0;
    bit is_mem, writes_reg;
    is_mem     = (m == 3'd3 || m == 3'd4);
    writes_reg = (m == 3'd1 || m == 3'd2 || m == 3'd4);
    case (m)
      3'd0:    base = 3;
      3'd4:    base = 5;
      default: base = 4;
    endcase
    exp_cyc = base + df + (is_mem ? dm : 0);
    check("at_fetch", state, 1);
    while (!done && cyc < 64) begin
      stop      = stp;
      mode      = (state == 3'd2) ? m : 3'($urandom);
      mem_ready = mem_req ? (waited >= (mem_addr_sel ? dm : df)) : 1'($urandom);
      @(negedge clk);
      cyc++;
      n_req  += int'(mem_req);
      n_addr += int'(mem_req && mem_addr_sel);
      n_we   += int'(mem_req && mem_we);
      n_ir   += int'(ir_we);
      n_pc   += int'(pc_we);
      n_reg  += int'(reg_we);
      if (!busy || (ir_we && (pc_we || reg_we)) || (reg_we && mem_we) || (mem_we && !mem_req))
        n_bad++;
      if (mem_req && !mem_ready) waited++;
      else waited = 0;
      if (pc_we) begin
        done = 1'b1;
        psel = pc_sel;
      end
      if (reg_we) begin
        rdst = reg_dst;
        wsel = wb_sel;
      end
      tick();
    end
    stop = 1'b0;
    check("instr_done", done, 1);
    exp_retired++;
    check("cycles", cyc, exp_cyc);
    check("mem_req_cycles", n_req, (1 + df) + (is_mem ? 1 + dm : 0));
    check("data_addr_cycles", n_addr, is_mem ? 1 + dm : 0);
    check("mem_we_cycles", n_we, (m == 3'd3) ? 1 + dm : 0);
    check("ir_we_cycles", n_ir, 1);
    check("pc_we_cycles", n_pc, 1);
    check("reg_we_cycles", n_reg, writes_reg ? 1 : 0);
    check("strobe_rules", n_bad, 0);
    check("pc_sel", psel, (m == 3'd0) ? 1 : 0);
    if (writes_reg) begin
      check("reg_dst", rdst, (m == 3'd1) ? 1 : 0);
      check("wb_sel", wsel, (m == 3'd4) ? 1 : 0);
    end
    check("retired", retired, exp_retired);
    check("boundary_state", state, stp ? 0 : 1);
    check("err_clear", err, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 3'd0;
    mem_ready = 1'b0;
    exp_retired = 0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int unsigned n;
    logic [2:0] m;
    logic stp;
    reset = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    mode = 3'd0;
    mem_ready = 1'b1;
    #3;
    check("rst_state", state, 0);
    check("rst_outputs", {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                          reg_we, reg_dst, wb_sel, busy, err}, 0);
    check("rst_retired", retired, 0);
    do_reset();

    // Directed R-type with instant memory, then lw with 2 wait cycles in MEM.
    check("idle_hold", state, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr(3'd1, 0, 0, 1'b0);
    run_instr(3'd4, 0, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      m   = 3'($urandom_range(0, 4));
      stp = ($urandom_range(0, 5) == 0);
      run_instr(m, $urandom_range(0, 3), $urandom_range(0, 3), stp);
      if (stp) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    // stop during lw returns to IDLE after WB
    run_instr(3'd4, 1, 1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;

    // Illegal mode in DECODE.
    mem_ready = 1'b1;
    mode = 3'd7;
    tick();
    check("illegal_decode", state, 2);
    tick();
    check("illegal_halt", state, 6);
    check("illegal_err", err, 1);
    check("illegal_busy", busy, 0);

    // Fetch timeout, then start/stop ignored in HALT.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (state == 3'd1 && n < 40) begin
      n += int'(mem_req);
      tick();
    end
    check("timeout_cycles", n, 15);
    check("timeout_state", state, 6);
    check("timeout_err", err, 1);
    check("timeout_mem_req", mem_req, 0);
    start = 1'b1;
    stop = 1'b1;
    mem_ready = 1'b1;
    repeat (5) tick();
    check("halt_sticky", state, 6);
    check("halt_strobes", {mem_req, ir_we, pc_we, reg_we, busy}, 0);
    check("halt_retired", retired, 0);
    start = 1'b0;
    stop = 1'b0;

    // Reset asserted while a store waits in MEM.
    do_reset();
    start = 1'b1;
    mem_ready = 1'b1;
    mode = 3'd3;
    tick();
    start = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b0;
    #1;
    check("sw_in_mem", {state, mem_req, mem_we}, {3'd4, 2'b11});
    reset = 1'b0;
    #1;
    check("rst_mid_mem_state", state, 0);
    check("rst_mid_mem_out", {mem_req, mem_we, pc_we, reg_we, busy}, 0);
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
